// File: rtl/cnn_pkg.sv
// Shared types and sizing for the 3x3 convolution front end.
// Default pixel format is signed fixed point: 9 integer bits, 4 fractional bits.
package cnn_pkg;
  localparam int INTEGER_BITS_DEF     = 9;
  localparam int FIXED_POINT_BITS_DEF = 4;
  localparam int LINE_WIDTH_DEF       = 512;
  localparam int PIXEL_W              = INTEGER_BITS_DEF + FIXED_POINT_BITS_DEF;
  localparam int WINDOW_W             = 9 * PIXEL_W;
  localparam int NUM_LB               = 4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Buffer index arithmetic wraps naturally at NUM_LB = 4.
  function automatic logic [1:0] sel_add(input logic [1:0] sel, input logic [1:0] off);
    return sel + off;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One image row of storage. Writes fill sequentially; each read step advances
// the read pointer and exposes three consecutive pixels, oldest column in the MSBs.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int PW    = PIXEL_W,
  parameter int DEPTH = LINE_WIDTH_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [PW-1:0]   i_data,
  input  logic            i_data_valid,
  input  logic            i_rd_data,
  output logic [3*PW-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [PW-1:0] line_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_p1, rd_ptr_p2;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_data_valid) wr_ptr_d = wr_ptr_q + AW'(1);
    if (i_rd_data)    rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // The +1/+2 taps wrap past the end of the row; the controller marks those windows invalid.
  assign rd_ptr_p1 = rd_ptr_q + AW'(1);
  assign rd_ptr_p2 = rd_ptr_q + AW'(2);
  assign o_data    = {line_mem[rd_ptr_q], line_mem[rd_ptr_p1], line_mem[rd_ptr_p2]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_data_valid) line_mem[wr_ptr_q] <= i_data;
  end
endmodule

// File: rtl/line_window_mux.sv
// Picks the three rows starting at rd_sel (oldest first) out of the four
// buffers and concatenates them into one 3x3 window.
module line_window_mux
  import cnn_pkg::*;
#(
  parameter int PW = PIXEL_W
) (
  input  logic [1:0]      i_rd_sel,
  input  logic [3*PW-1:0] i_rows [NUM_LB],
  output logic [9*PW-1:0] o_window
);
  logic [3*PW-1:0] row_old, row_mid, row_new;

  always_comb begin
    row_old  = i_rows[sel_add(i_rd_sel, 2'd0)];
    row_mid  = i_rows[sel_add(i_rd_sel, 2'd1)];
    row_new  = i_rows[sel_add(i_rd_sel, 2'd2)];
    o_window = {row_old, row_mid, row_new};
  end
endmodule

// File: rtl/line_window_ctrl.sv
// Raster pixel stream in, round-robin over four row buffers; once three rows
// are held, streams registered 3x3 windows out and pulses o_intr per row consumed.
module line_window_ctrl
  import cnn_pkg::*;
#(
  parameter int INTEGER_BITS     = INTEGER_BITS_DEF,
  parameter int FIXED_POINT_BITS = FIXED_POINT_BITS_DEF,
  parameter int LINE_WIDTH       = LINE_WIDTH_DEF
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]     i_data,
  input  logic                                         i_data_valid,
  output logic [9*(INTEGER_BITS+FIXED_POINT_BITS)-1:0] o_window,
  output logic                                         o_window_valid,
  output logic                                         o_intr,
  output logic                                         o_overflow,
  output state_t                                       o_state
);
  localparam int PW  = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int CW  = $clog2(LINE_WIDTH);
  localparam int PCW = $clog2(NUM_LB * LINE_WIDTH) + 1;
  localparam logic [PCW-1:0] CAP_LVL    = PCW'(NUM_LB * LINE_WIDTH);
  localparam logic [PCW-1:0] START_LVL  = PCW'(3 * LINE_WIDTH);
  localparam logic [CW-1:0]  LAST_COL   = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0]  LAST_VALID = CW'(LINE_WIDTH - 3);

  state_t           state_q, state_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [1:0]       wr_sel_q, wr_sel_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [1:0]       rd_sel_q, rd_sel_d;
  logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
  logic             intr_q, intr_d;
  logic             overflow_q, overflow_d;
  logic [9*PW-1:0]  window_q, window_d;
  logic             window_valid_q, window_valid_d;

  logic              accept;
  logic              rd;
  logic              lb_rst;
  logic [NUM_LB-1:0] lb_wr;
  logic [NUM_LB-1:0] lb_rd;
  logic [3*PW-1:0]   lb_data [NUM_LB];
  logic [9*PW-1:0]   mux_window;

  // i_data_valid is a strobe without backpressure: a pixel offered while all
  // four rows are occupied is lost and latched into the sticky overflow flag.
  assign accept = i_data_valid && (pix_cnt_q < CAP_LVL);
  assign rd     = (state_q == READ);
  assign lb_rst = ~i_rst_n;

  for (genvar b = 0; b < NUM_LB; b++) begin : g_lb
    assign lb_wr[b] = accept && (wr_sel_q == 2'(b));
    // Only the buffer three past rd_sel stays idle during a read pass.
    assign lb_rd[b] = rd && (2'(b) != sel_add(rd_sel_q, 2'd3));

    line_buffer #(
      .PW    (PW),
      .DEPTH (LINE_WIDTH)
    ) u_lb (
      .i_clk        (i_clk),
      .i_rst        (lb_rst),
      .i_data       (i_data),
      .i_data_valid (lb_wr[b]),
      .i_rd_data    (lb_rd[b]),
      .o_data       (lb_data[b])
    );
  end

  line_window_mux #(
    .PW (PW)
  ) u_mux (
    .i_rd_sel (rd_sel_q),
    .i_rows   (lb_data),
    .o_window (mux_window)
  );

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    wr_sel_d       = wr_sel_q;
    rd_cnt_d       = rd_cnt_q;
    rd_sel_d       = rd_sel_q;
    pix_cnt_d      = pix_cnt_q;
    intr_d         = 1'b0;
    overflow_d     = overflow_q | (i_data_valid & ~accept);
    window_d       = window_q;
    window_valid_d = 1'b0;

    if (accept) begin
      if (wr_cnt_q == LAST_COL) begin
        wr_cnt_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end

    if (accept && !rd)      pix_cnt_d = pix_cnt_q + PCW'(1);
    else if (!accept && rd) pix_cnt_d = pix_cnt_q - PCW'(1);

    case (state_q)
      IDLE: begin
        if (pix_cnt_q >= START_LVL) state_d = READ;
      end
      READ: begin
        window_d       = mux_window;
        // The final two steps read across the pointer wrap and only realign the buffers.
        window_valid_d = (rd_cnt_q <= LAST_VALID);
        if (rd_cnt_q == LAST_COL) begin
          state_d  = IDLE;
          rd_cnt_d = '0;
          rd_sel_d = rd_sel_q + 2'd1;
          intr_d   = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      wr_cnt_q       <= '0;
      wr_sel_q       <= '0;
      rd_cnt_q       <= '0;
      rd_sel_q       <= '0;
      pix_cnt_q      <= '0;
      intr_q         <= 1'b0;
      overflow_q     <= 1'b0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      wr_sel_q       <= wr_sel_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_sel_q       <= rd_sel_d;
      pix_cnt_q      <= pix_cnt_d;
      intr_q         <= intr_d;
      overflow_q     <= overflow_d;
      window_q       <= window_d;
      window_valid_q <= window_valid_d;
    end
  end

  assign o_window       = window_q;
  assign o_window_valid = window_valid_q;
  assign o_intr         = intr_q;
  assign o_overflow     = overflow_q;
  assign o_state        = state_q;
endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: full-size instance for window streaming, and a
// LINE_WIDTH=8 instance so the overflow path is reachable in a short run.
module tb_line_window_ctrl;
  import cnn_pkg::*;

  localparam int PW  = 13;
  localparam int WW  = 9 * PW;
  localparam int LW  = 512;
  localparam int SLW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [PW-1:0] i_data;
  logic          i_valid;
  logic [WW-1:0] o_window;
  logic          o_valid;
  logic          o_intr;
  logic          o_ovf;
  state_t        o_state;

  logic          s_rst_n;
  logic [PW-1:0] s_data;
  logic          s_valid;
  logic [WW-1:0] s_window;
  logic          s_wvalid;
  logic          s_intr;
  logic          s_ovf;
  state_t        s_state;

  line_window_ctrl #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .LINE_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_data_valid(i_valid),
    .o_window(o_window), .o_window_valid(o_valid), .o_intr(o_intr),
    .o_overflow(o_ovf), .o_state(o_state)
  );

  line_window_ctrl #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .LINE_WIDTH(SLW)) dut_small (
    .i_clk(clk), .i_rst_n(s_rst_n), .i_data(s_data), .i_data_valid(s_valid),
    .o_window(s_window), .o_window_valid(s_wvalid), .o_intr(s_intr),
    .o_overflow(s_ovf), .o_state(s_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] cap[$];
  bit   sb_en = 1'b0;
  int   valid_cnt;
  int   intr_cnt;
  logic [1:0] v_hist;

  typedef struct {
    int            phase;
    int            idx;
    logic [WW-1:0] exp;
  } vec_t;
  localparam int NTBL = 9;
  vec_t tbl[NTBL];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int r, input int c);
    if (r == 1 && c == 5) return 13'h1FF0;
    return PW'((r << 4) | (c & 15));
  endfunction

  function automatic logic [WW-1:0] w9(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                       input logic [PW-1:0] c, input logic [PW-1:0] d,
                                       input logic [PW-1:0] e, input logic [PW-1:0] f,
                                       input logic [PW-1:0] g, input logic [PW-1:0] h,
                                       input logic [PW-1:0] i);
    return {a, b, c, d, e, f, g, h, i};
  endfunction

  task automatic push_triple(input int k);
    for (int c = 0; c <= LW - 3; c++)
      exp_q.push_back(w9(pix(k, c), pix(k, c + 1), pix(k, c + 2),
                         pix(k + 1, c), pix(k + 1, c + 1), pix(k + 1, c + 2),
                         pix(k + 2, c), pix(k + 2, c + 1), pix(k + 2, c + 2)));
  endtask

  // Advance one cycle and sample outputs on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (sb_en) begin
      if (o_valid) begin
        valid_cnt++;
        cap.push_back(o_window);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra: got window %h expected none", o_window);
        end else begin
          check("sb_window", o_window, exp_q.pop_front());
        end
      end
      if (o_intr) begin
        intr_cnt++;
        check("intr_after_flush", WW'({v_hist, o_valid}), WW'(3'b100));
      end
      v_hist = {v_hist[0], o_valid};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_rows(input int first, input int nrows, input bit gaps);
    for (int r = first; r < first + nrows; r++) begin
      for (int c = 0; c < LW; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          i_valid = 1'b0;
          tick();
        end
        i_valid = 1'b1;
        i_data  = pix(r, c);
        tick();
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_intr(input int n, input int budget);
    int k = 0;
    while (intr_cnt < n && k < budget) begin
      tick();
      k++;
    end
    if (intr_cnt < n) begin
      tests++;
      fails++;
      $display("FAIL intr_timeout: got %0d pulses expected %0d", intr_cnt, n);
    end
  endtask

  task automatic start_phase();
    exp_q.delete();
    cap.delete();
    valid_cnt = 0;
    intr_cnt  = 0;
    v_hist    = 2'b00;
  endtask

  task automatic apply_table(input int ph);
    for (int i = 0; i < NTBL; i++) begin
      if (tbl[i].phase == ph) begin
        if (tbl[i].idx < cap.size()) begin
          check($sformatf("tbl_window[%0d]", tbl[i].idx), cap[tbl[i].idx], tbl[i].exp);
        end else begin
          tests++;
          fails++;
          $display("FAIL tbl_window[%0d]: got %0d windows expected more", tbl[i].idx, cap.size());
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_window"}, o_window, '0);
    check_bit({tag, "_valid"}, o_valid, 1'b0);
    check_bit({tag, "_intr"}, o_intr, 1'b0);
    check_bit({tag, "_ovf"}, o_ovf, 1'b0);
    check_bit({tag, "_state"}, o_state, IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n   = 1'b0;
    s_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    s_valid = 1'b0;
    s_data  = '0;

    tbl[0] = '{1, 0,    w9(13'h000, 13'h001, 13'h002, 13'h010, 13'h011, 13'h012, 13'h020, 13'h021, 13'h022)};
    tbl[1] = '{1, 3,    w9(13'h003, 13'h004, 13'h005, 13'h013, 13'h014, 13'h1FF0, 13'h023, 13'h024, 13'h025)};
    tbl[2] = '{1, 5,    w9(13'h005, 13'h006, 13'h007, 13'h1FF0, 13'h016, 13'h017, 13'h025, 13'h026, 13'h027)};
    tbl[3] = '{1, 509,  w9(13'h00D, 13'h00E, 13'h00F, 13'h01D, 13'h01E, 13'h01F, 13'h02D, 13'h02E, 13'h02F)};
    tbl[4] = '{2, 510,  w9(13'h010, 13'h011, 13'h012, 13'h020, 13'h021, 13'h022, 13'h030, 13'h031, 13'h032)};
    tbl[5] = '{2, 1020, w9(13'h020, 13'h021, 13'h022, 13'h030, 13'h031, 13'h032, 13'h040, 13'h041, 13'h042)};
    tbl[6] = '{2, 1531, w9(13'h031, 13'h032, 13'h033, 13'h041, 13'h042, 13'h043, 13'h051, 13'h052, 13'h053)};
    tbl[7] = '{2, 2550, w9(13'h050, 13'h051, 13'h052, 13'h060, 13'h061, 13'h062, 13'h070, 13'h071, 13'h072)};
    tbl[8] = '{2, 3059, w9(13'h05D, 13'h05E, 13'h05F, 13'h06D, 13'h06E, 13'h06F, 13'h07D, 13'h07E, 13'h07F)};

    repeat (3) tick();
    check_zero_outputs("reset");

    // Reset asserted in the middle of a write burst.
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      i_valid = 1'b1;
      i_data  = PW'($urandom_range(1, 8191));
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_midwrite");
    i_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Three rows with random gaps: one pass, first write lands at buffer 0 addr 0.
    start_phase();
    push_triple(0);
    sb_en = 1'b1;
    drive_rows(0, 3, 1'b1);
    check_bit("state_after_last_px", o_state, IDLE);
    tick();
    check_bit("state_read_start", o_state, READ);
    wait_intr(1, 2000);
    repeat (10) tick();
    check("p1_valid_cnt", WW'(valid_cnt), WW'(510));
    check("p1_intr_cnt", WW'(intr_cnt), WW'(1));
    check("p1_exp_left", WW'(exp_q.size()), WW'(0));
    check_bit("p1_state_idle", o_state, IDLE);
    apply_table(1);
    sb_en = 1'b0;

    // Reset while a read pass is in progress.
    drive_rows(3, 1, 1'b0);
    repeat (100) tick();
    check_bit("pre_abort_state", o_state, READ);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_midread");
    tick();
    tick();
    rst_n = 1'b1;

    // Eight rows back to back: six passes in buffer rotation order.
    start_phase();
    for (int k = 0; k < 6; k++) push_triple(k);
    sb_en = 1'b1;
    drive_rows(0, 8, 1'b0);
    wait_intr(6, 4000);
    repeat (10) tick();
    check("p2_valid_cnt", WW'(valid_cnt), WW'(3060));
    check("p2_intr_cnt", WW'(intr_cnt), WW'(6));
    check("p2_exp_left", WW'(exp_q.size()), WW'(0));
    check_bit("p2_state_idle", o_state, IDLE);
    check_bit("p2_no_overflow", o_ovf, 1'b0);
    apply_table(2);
    sb_en = 1'b0;

    // Overflow on the short-line instance: continuous input gains one pixel
    // per row over reads, so the 32-pixel store fills and pixel index 88 drops.
    s_rst_n = 1'b1;
    tick();
    s_valid = 1'b1;
    repeat (88) tick();
    check_bit("ovf_before_drop", s_ovf, 1'b0);
    tick();
    check_bit("ovf_on_drop", s_ovf, 1'b1);
    check_bit("ovf_drop_in_read", s_state, READ);
    repeat (20) tick();
    check_bit("ovf_sticky", s_ovf, 1'b1);
    s_valid = 1'b0;
    repeat (20) tick();
    check_bit("ovf_sticky_idle_input", s_ovf, 1'b1);
    s_rst_n = 1'b0;
    #1;
    check_bit("ovf_cleared", s_ovf, 1'b0);
    check_bit("small_valid_cleared", s_wvalid, 1'b0);
    check_bit("small_intr_cleared", s_intr, 1'b0);
    check("small_window_cleared", s_window, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
